// File: rtl/refill_pkg.sv
// Shared types and helpers for the refill responder and for benches that predict refill data.
package refill_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BURST = 2'd2
  } state_t;

  function automatic int off_w(input int words);
    return $clog2(words);
  endfunction

  // Clears the word-offset and byte-offset bits of an address.
  function automatic logic [63:0] line_base(input logic [63:0] addr, input int off_bits);
    return addr & ~((64'd1 << (off_bits + 2)) - 64'd1);
  endfunction

  function automatic logic [63:0] addr_to_data(input logic [63:0] addr, input logic [63:0] seed);
    return addr ^ seed;
  endfunction

endpackage

// File: rtl/refill_mem_responder_if.sv
// Request/response channel between the cache (master) and the refill responder (slave).
interface refill_mem_responder_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_last;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_last
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_last
  );
endinterface

// File: rtl/refill_mem_responder_burst_addr_gen.sv
// Line base / beat offset tracking for a refill burst. CRIT_WORD_FIRST_EN starts the
// burst at the requested word instead of word 0.
module burst_addr_gen
  import refill_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] req_addr,
  output logic [ADDR_W-1:0] start_addr,
  output logic [ADDR_W-1:0] cur_addr,
  output logic [ADDR_W-1:0] next_addr,
  output logic              next_last
);
  localparam int OFF_W = off_w(WORDS_PER_LINE);

  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] req_base;
  logic [OFF_W-1:0]  off;
  logic [OFF_W-1:0]  off_nxt;
  logic [OFF_W-1:0]  start_off;
  logic [OFF_W-1:0]  cnt;
  logic [OFF_W-1:0]  cnt_nxt;

  assign req_base = ADDR_W'(line_base(64'(req_addr), OFF_W));

`ifdef CRIT_WORD_FIRST_EN
  assign start_off = req_addr[OFF_W+1:2];
`else
  assign start_off = '0;
`endif

  // Offset wraps naturally at OFF_W bits; cnt counts beats so last is order-independent.
  assign off_nxt    = off + OFF_W'(1);
  assign cnt_nxt    = cnt + OFF_W'(1);
  assign start_addr = req_base + ADDR_W'({start_off, 2'b00});
  assign cur_addr   = base + ADDR_W'({off, 2'b00});
  assign next_addr  = base + ADDR_W'({off_nxt, 2'b00});
  assign next_last  = (cnt_nxt == OFF_W'(WORDS_PER_LINE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base <= '0;
      off  <= '0;
      cnt  <= '0;
    end else if (load) begin
      base <= req_base;
      off  <= start_off;
      cnt  <= '0;
    end else if (advance) begin
      off <= off_nxt;
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/refill_mem_responder.sv
// Backing-memory refill responder: one line request, fixed latency, then a multi-beat burst.
// Optional CRIT_WORD_FIRST_EN (in burst_addr_gen) selects critical-word-first beat order.
//
// state    | meaning
// ST_IDLE  | ready for a request
// ST_WAIT  | access latency countdown
// ST_BURST | streaming beats under rsp_ready
module refill_mem_responder
  import refill_pkg::*;
#(
  parameter int              ADDR_W         = 32,
  parameter int              DATA_W         = 32,
  parameter int              WORDS_PER_LINE = 4,
  parameter int              LATENCY        = 8,
  parameter logic [DATA_W-1:0] SEED         = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  refill_mem_responder_if.slave  bus,
  output logic                   busy
);
  localparam int LAT_W = 8;

  state_t            state;
  logic [LAT_W-1:0]  lat_cnt;
  logic              req_ready_r;
  logic              rsp_valid_r;
  logic              rsp_last_r;
  logic [DATA_W-1:0] rsp_data_r;

  logic              accept;
  logic              advance;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] next_addr;
  logic              next_last;

  assign bus.req_ready = req_ready_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_last  = rsp_last_r;
  assign bus.rsp_data  = rsp_data_r;

  assign accept  = (state == ST_IDLE) && bus.req_valid && req_ready_r;
  assign advance = (state == ST_BURST) && bus.rsp_ready && !rsp_last_r;

  function automatic logic [DATA_W-1:0] beat_data(input logic [ADDR_W-1:0] a);
    return DATA_W'(addr_to_data(64'(a), 64'(SEED)));
  endfunction

  burst_addr_gen #(
    .ADDR_W        (ADDR_W),
    .WORDS_PER_LINE(WORDS_PER_LINE)
  ) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .advance   (advance),
    .req_addr  (bus.req_addr),
    .start_addr(start_addr),
    .cur_addr  (cur_addr),
    .next_addr (next_addr),
    .next_last (next_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      lat_cnt     <= '0;
      req_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_last_r  <= 1'b0;
      rsp_data_r  <= '0;
      busy        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            req_ready_r <= 1'b0;
            busy        <= 1'b1;
            if (LATENCY == 0) begin
              // Address generator has not latched yet, so take the first beat from req_addr.
              state       <= ST_BURST;
              rsp_valid_r <= 1'b1;
              rsp_last_r  <= 1'b0;
              rsp_data_r  <= beat_data(start_addr);
            end else begin
              state   <= ST_WAIT;
              lat_cnt <= LAT_W'(LATENCY - 1);
            end
          end else begin
            req_ready_r <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (lat_cnt == '0) begin
            state       <= ST_BURST;
            rsp_valid_r <= 1'b1;
            rsp_last_r  <= 1'b0;
            rsp_data_r  <= beat_data(cur_addr);
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        ST_BURST: begin
          if (bus.rsp_ready) begin
            if (rsp_last_r) begin
              state       <= ST_IDLE;
              rsp_valid_r <= 1'b0;
              rsp_last_r  <= 1'b0;
              busy        <= 1'b0;
              req_ready_r <= 1'b1;
            end else begin
              rsp_data_r <= beat_data(next_addr);
              rsp_last_r <= next_last;
            end
          end
        end
        default: begin
          state       <= ST_IDLE;
          rsp_valid_r <= 1'b0;
          rsp_last_r  <= 1'b0;
          busy        <= 1'b0;
          req_ready_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
